// File: rtl/hdlc_rx_drain.sv
// -----------------------------------------------------------------------------
// hdlc_rx_drain
//
// Host-side bus master for the Rx path of the Hdlc controller. When the
// controller raises Rx_Ready, the block reads Rx_SC (overflow flag) and Rx_Len.
// It then reads exactly Rx_Len bytes from Rx_Buff and presents them on a
// valid/ready byte stream with start/end-of-frame markers. A frame whose length
// is 0 or above MAX_LEN is discarded by writing Rx_Drop. Frames delivered and
// frames dropped are counted in saturating 16-bit counters.
//
// Parameters
//   MAX_LEN      largest accepted frame length in bytes
//   FCS_EN       value of Rx_SC bit5 written at init and on each drop
//
// Ports
//   Clk, Rst     clock, synchronous active-high reset
//   Rx_Ready     controller has a received frame waiting
//   Address      register address (2 Rx_SC, 3 Rx_Buff, 4 Rx_Len), registered
//   ReadEnable   one-cycle read strobe, registered
//   WriteEnable  one-cycle write strobe, registered
//   DataIn       write data to the controller, registered
//   DataOut      read data from the controller, valid the cycle after a read
//   M_Data       stream byte
//   M_Valid      stream byte valid
//   M_Ready      downstream accepts the byte
//   M_Sof        first byte of a frame (qualified by M_Valid)
//   M_Eof        last byte of a frame (qualified by M_Valid)
//   M_Err        last byte of a frame that was flagged as overflowed
//   FrameCnt     frames delivered, saturating
//   DropCnt      frames dropped, saturating
// -----------------------------------------------------------------------------
module hdlc_rx_drain #(
    parameter int MAX_LEN = 126,
    parameter bit FCS_EN  = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rx_Ready,
    output logic [2:0]  Address,
    output logic        ReadEnable,
    output logic        WriteEnable,
    output logic [7:0]  DataIn,
    input  logic [7:0]  DataOut,
    output logic [7:0]  M_Data,
    output logic        M_Valid,
    input  logic        M_Ready,
    output logic        M_Sof,
    output logic        M_Eof,
    output logic        M_Err,
    output logic [15:0] FrameCnt,
    output logic [15:0] DropCnt
);

    localparam logic [2:0] ADDR_SC   = 3'd2;
    localparam logic [2:0] ADDR_BUFF = 3'd3;
    localparam logic [2:0] ADDR_LEN  = 3'd4;

    localparam logic [7:0] SC_INIT = {2'b00, FCS_EN, 5'b00000};
    localparam logic [7:0] SC_DROP = {2'b00, FCS_EN, 3'b000, 1'b1, 1'b0};

    // Widened by one bit so a length of 255 compares correctly against MAX_LEN.
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        RD_STAT,
        CAP_STAT,
        RD_LEN,
        CAP_LEN,
        BYTE_REQ,
        BYTE_CAP,
        BYTE_OUT,
        DROP,
        WAIT_CLR
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic [7:0]  rem_q, rem_d;
    logic        ovf_q, ovf_d;
    logic        first_q, first_d;
    logic [7:0]  mdata_q, mdata_d;
    logic        mvalid_q, mvalid_d;
    logic        msof_q, msof_d;
    logic        meof_q, meof_d;
    logic        merr_q, merr_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] dcnt_q, dcnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic len_bad(input logic [7:0] len);
        return (len == 8'd0) || ({1'b0, len} > MAX_LEN_W);
    endfunction

    // The bus strobes are registered: each strobe is raised on the edge that
    // enters the state which owns it, so it is visible during that state. The
    // INIT write is the exception -- INIT only exists under reset, so its
    // write appears during the first IDLE cycle.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        re_d     = 1'b0;
        we_d     = 1'b0;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        first_d  = first_q;
        mdata_d  = mdata_q;
        mvalid_d = mvalid_q;
        msof_d   = msof_q;
        meof_d   = meof_q;
        merr_d   = merr_q;
        fcnt_d   = fcnt_q;
        dcnt_d   = dcnt_q;

        case (state_q)
            INIT: begin
                we_d    = 1'b1;
                addr_d  = ADDR_SC;
                din_d   = SC_INIT;
                state_d = IDLE;
            end
            IDLE: begin
                if (Rx_Ready) begin
                    re_d    = 1'b1;
                    addr_d  = ADDR_SC;
                    state_d = RD_STAT;
                end
            end
            RD_STAT: begin
                state_d = CAP_STAT;
            end
            CAP_STAT: begin
                ovf_d   = DataOut[4];
                re_d    = 1'b1;
                addr_d  = ADDR_LEN;
                state_d = RD_LEN;
            end
            RD_LEN: begin
                state_d = CAP_LEN;
            end
            CAP_LEN: begin
                rem_d   = DataOut;
                first_d = 1'b1;
                if (len_bad(DataOut)) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_SC;
                    din_d   = SC_DROP;
                    state_d = DROP;
                end else begin
                    re_d    = 1'b1;
                    addr_d  = ADDR_BUFF;
                    state_d = BYTE_REQ;
                end
            end
            BYTE_REQ: begin
                state_d = BYTE_CAP;
            end
            BYTE_CAP: begin
                mdata_d  = DataOut;
                mvalid_d = 1'b1;
                msof_d   = first_q;
                meof_d   = (rem_q == 8'd1);
                merr_d   = (rem_q == 8'd1) && ovf_q;
                rem_d    = rem_q - 8'd1;
                first_d  = 1'b0;
                state_d  = BYTE_OUT;
            end
            BYTE_OUT: begin
                // Stream outputs hold until the handshake; no new read is
                // issued while a byte is still pending.
                if (M_Ready) begin
                    mvalid_d = 1'b0;
                    msof_d   = 1'b0;
                    meof_d   = 1'b0;
                    merr_d   = 1'b0;
                    if (rem_q != 8'd0) begin
                        re_d    = 1'b1;
                        addr_d  = ADDR_BUFF;
                        state_d = BYTE_REQ;
                    end else begin
                        fcnt_d  = sat_inc(fcnt_q);
                        state_d = WAIT_CLR;
                    end
                end
            end
            DROP: begin
                dcnt_d  = sat_inc(dcnt_q);
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                // Rx_Ready must be seen low before the next frame is taken,
                // otherwise a slow-to-clear Rx_Ready would re-read this frame.
                if (!Rx_Ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= INIT;
            addr_q   <= 3'd0;
            din_q    <= 8'd0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            rem_q    <= 8'd0;
            ovf_q    <= 1'b0;
            first_q  <= 1'b0;
            mdata_q  <= 8'd0;
            mvalid_q <= 1'b0;
            msof_q   <= 1'b0;
            meof_q   <= 1'b0;
            merr_q   <= 1'b0;
            fcnt_q   <= 16'd0;
            dcnt_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            re_q     <= re_d;
            we_q     <= we_d;
            rem_q    <= rem_d;
            ovf_q    <= ovf_d;
            first_q  <= first_d;
            mdata_q  <= mdata_d;
            mvalid_q <= mvalid_d;
            msof_q   <= msof_d;
            meof_q   <= meof_d;
            merr_q   <= merr_d;
            fcnt_q   <= fcnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign Address     = addr_q;
    assign DataIn      = din_q;
    assign ReadEnable  = re_q;
    assign WriteEnable = we_q;
    assign M_Data      = mdata_q;
    assign M_Valid     = mvalid_q;
    assign M_Sof       = msof_q;
    assign M_Eof       = meof_q;
    assign M_Err       = merr_q;
    assign FrameCnt    = fcnt_q;
    assign DropCnt     = dcnt_q;

endmodule

// File: doc/hdlc_rx_drain.md
# hdlc_rx_drain

Host-side bus master that sits directly downstream of the `Hdlc` controller's Rx path, on its 3-bit address/8-bit data register bus. On `Rx_Ready` it reads `Rx_SC` and `Rx_Len`, then drains the frame from `Rx_Buff`. The bytes go out on a valid/ready byte stream with start-of-frame and end-of-frame markers. Invalid frames are dropped through `Rx_Drop`, and per-frame statistics are kept.

## Interface
Parameters:
- `MAX_LEN`, default 126: largest accepted frame length in bytes (128-byte buffer minus 2 FCS bytes).
- `FCS_EN`, default 1: value written to `Rx_SC` bit5 (`Rx_FCSen`) at init and on every drop write.

Ports:
- `Clk`  in  1  system clock, same clock as `Hdlc`.
- `Rst`  in  1  reset, synchronous, active-high.
- `Rx_Ready`  in  1  `Hdlc` Rx_Ready pin; a frame is available in the Rx buffer.
- `Address`  out  3  `Hdlc` register address. Map: 2 = `Rx_SC`, 3 = `Rx_Buff`, 4 = `Rx_Len`.
- `ReadEnable`  out  1  one-cycle read strobe.
- `WriteEnable`  out  1  one-cycle write strobe.
- `DataIn`  out  8  write data to `Hdlc`.
- `DataOut`  in  8  read data from `Hdlc`, valid the cycle after `ReadEnable`.
- `M_Data`  out  8  stream byte.
- `M_Valid`  out  1  stream byte valid.
- `M_Ready`  in  1  downstream accepts the byte.
- `M_Sof`  out  1  marks the first byte of a frame; qualified by `M_Valid`.
- `M_Eof`  out  1  marks the last byte of a frame; qualified by `M_Valid`.
- `M_Err`  out  1  set on the last byte when `Rx_SC` bit4 (`Rx_Overflow`) was set.
- `FrameCnt`  out  16  frames delivered, saturating.
- `DropCnt`  out  16  frames dropped, saturating.

## Operation
- States: `INIT`, `IDLE`, `RD_STAT`, `CAP_STAT`, `RD_LEN`, `CAP_LEN`, `BYTE_REQ`, `BYTE_CAP`, `BYTE_OUT`, `DROP`, `WAIT_CLR`.
- **INIT:** write `Rx_SC` = {2'b0, `FCS_EN`, 5'b0}, then go to `IDLE`.
- **IDLE:** wait for `Rx_Ready`=1, then go to `RD_STAT`.
- **RD_STAT / CAP_STAT:** read `Rx_SC` at address 2 and latch the overflow flag from bit4.
- **RD_LEN / CAP_LEN:** read `Rx_Len` at address 4 into `Remaining` (8 bits).
  - If `Remaining` is 0 or greater than `MAX_LEN`, go to `DROP`.
  - Otherwise go to `BYTE_REQ`.
- **BYTE_REQ:** `ReadEnable`=1, `Address`=3.
- **BYTE_CAP:** load `DataOut` into `M_Data` and set `M_Valid`. Decrement `Remaining`.
  - `M_Sof` = first byte of the frame.
  - `M_Eof` = (`Remaining` before decrement == 1).
  - `M_Err` = `M_Eof` & latched overflow flag.
- **BYTE_OUT:** hold all stream outputs until `M_Ready`.
  - On the handshake, clear `M_Valid`.
  - If `Remaining` != 0, go to `BYTE_REQ`.
  - Otherwise increment `FrameCnt` and go to `WAIT_CLR`.
- **DROP:** write `Rx_SC` = {2'b0, `FCS_EN`, 3'b0, 1'b1, 1'b0} (`Rx_Drop`, bit1). Increment `DropCnt`, then go to `WAIT_CLR`.
- **WAIT_CLR:** wait for `Rx_Ready`=0, then go to `IDLE`. This prevents re-reading the same frame.
- Bus outputs: `Address`, `DataIn`, `ReadEnable` and `WriteEnable` are registered. A strobe is never asserted for more than one cycle. `ReadEnable` and `WriteEnable` are never high in the same cycle.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset values: all outputs 0, state `INIT`, `Remaining`=0, overflow flag=0.
- First `INIT` write strobe: the first cycle after `Rst` deasserts.
- Reset mid-frame: the frame is abandoned and `M_Valid` drops on the next edge. `INIT` is re-executed; no counter is incremented for the abandoned frame.
- Latency from `Rx_Ready` rise (sampled in `IDLE`) to the first `M_Valid`: 7 cycles (`RD_STAT`, `CAP_STAT`, `RD_LEN`, `CAP_LEN`, `BYTE_REQ`, `BYTE_CAP`, then valid).
- Throughput: 3 cycles per byte when `M_Ready` is held at 1.
- `M_Ready` low stalls indefinitely. `M_Data`, `M_Sof`, `M_Eof` and `M_Err` stay stable while `M_Valid`=1.
- Single-byte frame: `M_Sof` and `M_Eof` are both 1 on the same beat.
- `Rx_Ready` falling before the drain completes is ignored; the block reads exactly `Remaining` bytes.
- A `Rx_Ready` rise in `WAIT_CLR` is not acted on until `Rx_Ready` has been seen low.

## Test plan
- **Reset, then a 4-byte frame** {AA,55,0F,F0}, `Rx_Ready`=1, `Rx_Len`=4, `M_Ready`=1 → four stream beats in order. `M_Sof` is on AA only and `M_Eof` on F0 only. `FrameCnt`=1, `DropCnt`=0, and exactly 4 reads at address 3.
- **Backpressure:** same 4-byte frame with `M_Ready` low for 5 cycles on each beat → identical byte order. No `ReadEnable` is issued while `M_Valid`=1, and the outputs stay stable across each stall.
- **Length rules:** `Rx_Len`=0 → one write of 8'h22 (with `FCS_EN`=1) to address 2, no stream output, `DropCnt`=1. Same result for `Rx_Len`=127.
- **Overflow:** `Rx_SC` bit4 set with `Rx_Len`=126 → 126 beats delivered, and `M_Err`=1 on the last beat only.
- **Reset mid-frame:** assert `Rst` after the 2nd byte is accepted → `M_Valid`=0 after one edge. On release, an `INIT` write of 8'h20 occurs and the counters read 0.
- **Counter saturation:** preload or force `FrameCnt`=16'hFFFF, then complete a frame → `FrameCnt` stays at 16'hFFFF.
